// File: rtl/halt_ctrl_if.sv
// Halt controller bus: maskable halt requests, resume/step pulses and halt status.
interface halt_ctrl_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned CNT_W   = 8
);
    logic [NUM_SRC-1:0] halt_req;
    logic [NUM_SRC-1:0] src_mask;
    logic               resume;
    logic               step;
    logic               pc_hold;
    logic               halted;
    logic [NUM_SRC-1:0] halt_cause;
    logic [CNT_W-1:0]   halt_count;

    modport master (
        output halt_req, src_mask, resume, step,
        input  pc_hold, halted, halt_cause, halt_count
    );

    modport slave (
        input  halt_req, src_mask, resume, step,
        output pc_hold, halted, halt_cause, halt_count
    );
endinterface

// File: rtl/halt_ctrl.sv
// Multi-source halt/resume controller: merges masked halt requests into one PC hold,
// drains the pipeline, then supports resume and single-step while halted.
module halt_ctrl #(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    halt_ctrl_if.slave  bus
);
    localparam int unsigned DCNT_W = 8;
    localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);
    localparam bit DRAIN_EN = (DRAIN_CYCLES != 0);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2,
        S_STEP   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DCNT_W-1:0]   drain_q, drain_d;
    logic                halted_q, halted_d;
    logic [NUM_SRC-1:0]  cause_q, cause_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [NUM_SRC-1:0]  req_v;
    logic                any_req;
    logic                pc_hold_c;

    assign req_v   = bus.halt_req & bus.src_mask;
    assign any_req = |req_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            drain_q  <= '0;
            halted_q <= 1'b0;
            cause_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            halted_q <= halted_d;
            cause_q  <= cause_d;
            count_q  <= count_d;
        end
    end

    // Next state, sticky cause accumulation and the same-cycle PC hold.
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        cause_d   = cause_q;
        count_d   = count_q;
        pc_hold_c = 1'b0;

        unique case (state_q)
            S_RUN: begin
                pc_hold_c = any_req;
                if (any_req) begin
                    cause_d = req_v;
                    count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
                    if (DRAIN_EN) begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else begin
                        state_d = S_HALTED;
                    end
                end
            end
            S_DRAIN: begin
                pc_hold_c = 1'b1;
                cause_d   = cause_q | req_v;
                if (drain_q == '0) begin
                    state_d = S_HALTED;
                end else begin
                    drain_d = drain_q - DCNT_W'(1);
                end
            end
            S_HALTED: begin
                pc_hold_c = 1'b1;
                cause_d   = cause_q | req_v;
                if (bus.resume) begin
                    state_d = S_RUN;
                    cause_d = '0;
                end else if (bus.step) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                pc_hold_c = 1'b0;
                cause_d   = cause_q | req_v;
                state_d   = S_HALTED;
            end
            default: state_d = S_RUN;
        endcase

        halted_d = (state_d == S_HALTED);
    end

    assign bus.pc_hold    = pc_hold_c;
    assign bus.halted     = halted_q;
    assign bus.halt_cause = cause_q;
    assign bus.halt_count = count_q;
endmodule

// File: tb/tb_halt_ctrl.sv
// Self-checking bench for halt_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_halt_ctrl;
    localparam int unsigned NS = 4;
    localparam int unsigned D  = 2;
    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic rst;
    halt_ctrl_if #(.NUM_SRC(NS), .CNT_W(CW)) bus ();

    halt_ctrl #(.NUM_SRC(NS), .DRAIN_CYCLES(D), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: a halt "session" with an age in cycles since acceptance.
    bit          m_valid  = 1'b0;
    bit          m_active = 1'b0;
    bit          m_step   = 1'b0;
    int          m_age    = 0;
    logic [NS-1:0] m_cause = '0;
    int          m_count  = 0;

    always @(posedge clk) begin
        logic [NS-1:0] r;
        r = bus.halt_req & bus.src_mask;
        if (rst) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_step   = 1'b0;
            m_age    = 0;
            m_cause  = '0;
            m_count  = 0;
        end else if (!m_active) begin
            if (r != 0) begin
                m_active = 1'b1;
                m_age    = 1;
                m_cause  = r;
                m_count  = (m_count < 255) ? m_count + 1 : 255;
            end
        end else if (m_step) begin
            m_step  = 1'b0;
            m_cause = m_cause | r;
        end else if (m_age <= int'(D)) begin
            m_age   = m_age + 1;
            m_cause = m_cause | r;
        end else if (bus.resume) begin
            m_active = 1'b0;
            m_cause  = '0;
        end else begin
            m_cause = m_cause | r;
            if (bus.step) m_step = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        logic [NS-1:0] r;
        bit exp_hold, exp_halted;
        r          = bus.halt_req & bus.src_mask;
        exp_hold   = m_active ? !m_step : (r != 0);
        exp_halted = m_active && !m_step && (m_age > int'(D));
        chk("model_pc_hold", 32'(bus.pc_hold), 32'(exp_hold));
        chk("model_halted", 32'(bus.halted), 32'(exp_halted));
        chk("model_cause", 32'(bus.halt_cause), 32'(m_cause));
        chk("model_count", 32'(bus.halt_count), 32'(m_count));
    endtask

    // Apply inputs for one cycle, then compare against the model mid-cycle.
    task automatic drive(input logic [NS-1:0] req, input logic [NS-1:0] mask,
                         input logic res, input logic stp, input logic r);
        @(posedge clk);
        #1;
        bus.halt_req = req;
        bus.src_mask = mask;
        bus.resume   = res;
        bus.step     = stp;
        rst          = r;
        @(negedge clk);
        if (m_valid) model_compare();
    endtask

    task automatic idle();
        drive('0, 4'hF, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.halt_req = '0;
        bus.src_mask = '0;
        bus.resume   = 1'b0;
        bus.step     = 1'b0;
        rst          = 1'b1;

        drive('0, 4'hF, 1'b0, 1'b0, 1'b1);
        idle();
        chk("rst_halted", 32'(bus.halted), 32'h0);
        chk("rst_cause", 32'(bus.halt_cause), 32'h0);
        chk("rst_count", 32'(bus.halt_count), 32'h0);
        chk("rst_pc_hold", 32'(bus.pc_hold), 32'h0);

        // 1: single request, same-cycle hold, halted three cycles later
        drive(4'b0010, 4'hF, 1'b0, 1'b0, 1'b0);
        chk("t1_hold_same_cycle", 32'(bus.pc_hold), 32'h1);
        idle();
        chk("t1_drain1_halted", 32'(bus.halted), 32'h0);
        idle();
        chk("t1_drain2_halted", 32'(bus.halted), 32'h0);
        idle();
        chk("t1_halted", 32'(bus.halted), 32'h1);
        chk("t1_cause", 32'(bus.halt_cause), 32'h2);
        chk("t1_count", 32'(bus.halt_count), 32'h1);

        // 2: single step
        drive('0, 4'hF, 1'b0, 1'b1, 1'b0);
        chk("t2_pre_hold", 32'(bus.pc_hold), 32'h1);
        idle();
        chk("t2_step_hold", 32'(bus.pc_hold), 32'h0);
        chk("t2_step_halted", 32'(bus.halted), 32'h0);
        idle();
        chk("t2_back_hold", 32'(bus.pc_hold), 32'h1);
        chk("t2_back_halted", 32'(bus.halted), 32'h1);
        chk("t2_cause", 32'(bus.halt_cause), 32'h2);
        chk("t2_count", 32'(bus.halt_count), 32'h1);

        // 3: resume wins over step
        drive('0, 4'hF, 1'b1, 1'b1, 1'b0);
        idle();
        chk("t3_halted", 32'(bus.halted), 32'h0);
        chk("t3_hold", 32'(bus.pc_hold), 32'h0);
        chk("t3_cause", 32'(bus.halt_cause), 32'h0);

        // 4: masking and cause accumulation during drain
        drive(4'b0001, 4'b1110, 1'b0, 1'b0, 1'b0);
        chk("t4_masked_hold", 32'(bus.pc_hold), 32'h0);
        drive(4'b0001, 4'b1110, 1'b0, 1'b0, 1'b0);
        chk("t4_masked_count", 32'(bus.halt_count), 32'h1);
        drive(4'b0100, 4'b1110, 1'b0, 1'b0, 1'b0);
        drive(4'b1000, 4'b1110, 1'b0, 1'b0, 1'b0);
        chk("t4_cause_drain1", 32'(bus.halt_cause), 32'h4);
        idle();
        idle();
        chk("t4_cause", 32'(bus.halt_cause), 32'hC);
        chk("t4_count", 32'(bus.halt_count), 32'h2);
        chk("t4_halted", 32'(bus.halted), 32'h1);
        drive('0, 4'hF, 1'b1, 1'b0, 1'b0);
        idle();

        // 5: counter saturation
        for (int i = 0; i < 260; i++) begin
            drive(4'b0001, 4'hF, 1'b0, 1'b0, 1'b0);
            idle();
            idle();
            drive('0, 4'hF, 1'b1, 1'b0, 1'b0);
        end
        idle();
        chk("t5_saturated", 32'(bus.halt_count), 32'hFF);

        // 6a: reset in second drain cycle
        drive(4'b0010, 4'hF, 1'b0, 1'b0, 1'b0);
        idle();
        drive('0, 4'hF, 1'b0, 1'b0, 1'b1);
        idle();
        chk("t6a_hold", 32'(bus.pc_hold), 32'h0);
        chk("t6a_halted", 32'(bus.halted), 32'h0);
        chk("t6a_cause", 32'(bus.halt_cause), 32'h0);
        chk("t6a_count", 32'(bus.halt_count), 32'h0);

        // 6b: reset in the step cycle
        drive(4'b1000, 4'hF, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        drive('0, 4'hF, 1'b0, 1'b1, 1'b0);
        drive('0, 4'hF, 1'b0, 1'b0, 1'b1);
        chk("t6b_in_step_hold", 32'(bus.pc_hold), 32'h0);
        idle();
        chk("t6b_hold", 32'(bus.pc_hold), 32'h0);
        chk("t6b_halted", 32'(bus.halted), 32'h0);
        chk("t6b_cause", 32'(bus.halt_cause), 32'h0);
        chk("t6b_count", 32'(bus.halt_count), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [NS-1:0] rq, mk;
            logic rs, st, rr;
            rq = ($urandom_range(0, 5) == 0) ? NS'($urandom) : '0;
            mk = NS'($urandom);
            rs = ($urandom_range(0, 5) == 0);
            st = ($urandom_range(0, 3) == 0);
            rr = ($urandom_range(0, 199) == 0);
            drive(rq, mk, rs, st, rr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
